// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, issues imem requests, buffers responses in order for IF/ID.
// Optional misaligned-redirect fault tuple enabled by defining IF_MISALIGN_CHECK_EN.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] pc_if_o,
  output logic [31:0] pc4_if_o,
  output logic [31:0] instr_if_o,
  output logic        instr_valid_if_o,
  output logic        fetch_fault_if_o
);

  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CNT_W = 4;
  localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(BUF_DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(BUF_DEPTH - 1);

  logic [31:0]      fetch_pc;
  logic [31:0]      fifo_pc    [BUF_DEPTH];
  logic [31:0]      fifo_instr [BUF_DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [CNT_W-1:0] fifo_cnt, out_cnt, disc_cnt;
  logic             fault_hold, fault_pend;

  logic [31:0]      target_pc;
  logic             misalign;
  logic             fifo_empty, fault_show, pop, fifo_pop, grant;
  logic             rsp_disc, rsp_push;
  logic [31:0]      rsp_pc;
  logic [CNT_W:0]   in_use;

`ifdef IF_MISALIGN_CHECK_EN
  assign target_pc        = redirect_pc_i;
  assign misalign         = (redirect_pc_i[1:0] != 2'b00);
  assign fetch_fault_if_o = fault_show;
`else
  assign target_pc        = redirect_pc_i & 32'hFFFF_FFFC;
  assign misalign         = 1'b0;
  assign fetch_fault_if_o = 1'b0;
`endif

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  // The fault tuple waits until every response owed to the flushed path has drained.
  assign fifo_empty       = (fifo_cnt == '0);
  assign fault_show       = fault_hold & fault_pend & (disc_cnt == '0);
  assign instr_valid_if_o = !fifo_empty | fault_show;
  assign pop              = instr_valid_if_o & !stall_i & !redirect_i;
  assign fifo_pop         = pop & !fifo_empty;

  assign in_use     = {1'b0, fifo_cnt} + {1'b0, out_cnt} + {1'b0, disc_cnt};
  assign imem_req_o = rst_n & !redirect_i & !fault_hold &
                      ((in_use - {{CNT_W{1'b0}}, pop}) < DEPTH_C);
  assign imem_addr_o = fetch_pc;
  assign grant       = imem_req_o & imem_gnt_i;

  // Live requests are consecutive words, so the oldest one sits out_cnt words behind fetch_pc.
  assign rsp_disc = imem_rvalid_i & (disc_cnt != '0);
  assign rsp_push = imem_rvalid_i & (disc_cnt == '0);
  assign rsp_pc   = fetch_pc - {26'd0, out_cnt, 2'b00};

  always_comb begin
    pc_if_o    = '0;
    instr_if_o = '0;
    pc4_if_o   = '0;
    if (!fifo_empty) begin
      pc_if_o    = fifo_pc[rd_ptr];
      instr_if_o = fifo_instr[rd_ptr];
    end else if (fault_show) begin
      pc_if_o    = fetch_pc;
      instr_if_o = 32'h0000_0013;
    end
    if (instr_valid_if_o) pc4_if_o = pc_if_o + 32'd4;
  end

  always_ff @(posedge clk) begin
    if (rsp_push && !redirect_i) begin
      fifo_pc[wr_ptr]    <= rsp_pc;
      fifo_instr[wr_ptr] <= imem_rdata_i;
    end
  end

  // A redirect flushes everything live and converts in-flight requests into discards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc   <= RESET_PC;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_cnt   <= '0;
      out_cnt    <= '0;
      disc_cnt   <= '0;
      fault_hold <= 1'b0;
      fault_pend <= 1'b0;
    end else if (redirect_i) begin
      fetch_pc   <= target_pc;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_cnt   <= '0;
      out_cnt    <= '0;
      disc_cnt   <= disc_cnt + out_cnt - CNT_W'(imem_rvalid_i);
      fault_hold <= misalign;
      fault_pend <= misalign;
    end else begin
      if (grant) fetch_pc <= fetch_pc + 32'd4;
      out_cnt  <= out_cnt + CNT_W'(grant) - CNT_W'(rsp_push);
      if (rsp_disc) disc_cnt <= disc_cnt - 1'b1;
      if (rsp_push) wr_ptr <= next_ptr(wr_ptr);
      if (fifo_pop) rd_ptr <= next_ptr(rd_ptr);
      fifo_cnt <= fifo_cnt + CNT_W'(rsp_push) - CNT_W'(fifo_pop);
      if (pop && fault_show) fault_pend <= 1'b0;
    end
  end

endmodule
